// File: rtl/pip_ifq_rv32_pkg.sv
// Shared definitions for the RV32 instruction fetch queue: widths, the NOP word and the entry layout.
package pip_ifq_rv32_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RV32_NOP = 32'h00000013;

    localparam int ENTRY_W         = 65;
    localparam int ENTRY_MIS_BIT   = 0;
    localparam int ENTRY_INSTR_LSB = 1;
    localparam int ENTRY_PC_LSB    = 33;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } ifq_entry_t;

    // Builds a queue entry; any nonzero low PC bit marks the fetch as misaligned.
    function automatic ifq_entry_t make_entry(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
        ifq_entry_t e;
        e.pc       = pc;
        e.instr    = instr;
        e.misalign = |pc[1:0];
        return e;
    endfunction

endpackage

// File: rtl/pip_ifq_rv32_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue, bundled as one interface.
interface pip_ifq_rv32_if;
    import pip_ifq_rv32_pkg::*;

    logic [XLEN-1:0] iPCADDR;
    logic [XLEN-1:0] iINSTR;
    logic            iIVALID;
    logic            iBRANCH;
    logic            iStallD;
    logic [XLEN-1:0] oINSTR;
    logic [XLEN-1:0] oPC;
    logic            oMISALIGN;
    logic            oVALID;
    logic            oFULL;

    modport master (
        output iPCADDR, iINSTR, iIVALID, iBRANCH, iStallD,
        input  oINSTR, oPC, oMISALIGN, oVALID, oFULL
    );

    modport slave (
        input  iPCADDR, iINSTR, iIVALID, iBRANCH, iStallD,
        output oINSTR, oPC, oMISALIGN, oVALID, oFULL
    );

endinterface

// File: rtl/pip_ifq_rv32_mem.sv
// ifq_mem_rv32: DEPTH x 65-bit entry array, one synchronous write port and one asynchronous read port.
// Deliberately unreset: whether a slot holds a live entry is decided by the queue count.
import pip_ifq_rv32_pkg::*;

module ifq_mem_rv32 #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Entry write on push.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pip_ifq_rv32.sv
// pip_ifq_rv32: fetch queue between ICache return and decode, flushed in one cycle on a taken branch.
// Optional IFQ_BYPASS_EN: an empty queue forwards the incoming fetch to decode in the same cycle.
import pip_ifq_rv32_pkg::*;

module pip_ifq_rv32 #(
    parameter int DEPTH = 2
) (
    input logic           iCLK,
    input logic           iRST,
    pip_ifq_rv32_if.slave bus
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full_s, empty_s, push_s, pop_s, byp_s;
    ifq_entry_t    wr_entry_s, head_s;

    assign wr_entry_s = make_entry(bus.iPCADDR, bus.iINSTR);

    ifq_mem_rv32 #(.DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk_i   (iCLK),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    // Push/pop decisions and next pointer/count; a branch overrides everything.
    always_comb begin
        full_s  = (count_q == FULL_CNT);
        empty_s = (count_q == {(PW+1){1'b0}});
`ifdef IFQ_BYPASS_EN
        byp_s   = empty_s & bus.iIVALID & ~bus.iBRANCH & ~iRST;
`else
        byp_s   = 1'b0;
`endif
        pop_s   = ~empty_s & ~bus.iStallD & ~bus.iBRANCH;
        push_s  = bus.iIVALID & ~full_s & ~bus.iBRANCH & ~(byp_s & ~bus.iStallD);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.iBRANCH) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Decode-facing outputs: bypassed fetch, else head entry, else NOP.
    always_comb begin
        bus.oINSTR    = RV32_NOP;
        bus.oPC       = {XLEN{1'b0}};
        bus.oMISALIGN = 1'b0;
        bus.oVALID    = 1'b0;
        bus.oFULL     = full_s;
        if (byp_s) begin
            bus.oINSTR    = wr_entry_s.instr;
            bus.oPC       = wr_entry_s.pc;
            bus.oMISALIGN = wr_entry_s.misalign;
            bus.oVALID    = 1'b1;
        end else if (!empty_s) begin
            bus.oINSTR    = head_s.instr;
            bus.oPC       = head_s.pc;
            bus.oMISALIGN = head_s.misalign;
            bus.oVALID    = 1'b1;
        end else begin
            bus.oVALID    = 1'b0;
        end
    end

endmodule
